// File: rtl/seq_addsub_pkg.sv
// Shared types and constants for the sliced sequential adder/subtractor.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the 4-bit flags vector {N, Z, C, V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_addsub_if.sv
// Request/response bus of seq_addsub: one operand request channel, one result channel.
interface seq_addsub_if #(
    parameter int WIDTH = 8
);
    // Both channels use valid/ready: a beat transfers on the rising edge where valid and
    // ready are both high; once raised, valid and its payload stay put until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/seq_addsub_slice.sv
// Combinational SLICE-bit adder; also reports the carry into its MSB for overflow detection.
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x_i,
    input  logic [SLICE-1:0] y_i,
    input  logic             ci_i,
    output logic [SLICE-1:0] s_o,
    output logic             co_o,
    output logic             cm_o
);

    logic [SLICE:0] sum;

    assign sum  = {1'b0, x_i} + {1'b0, y_i} + (SLICE+1)'(ci_i);
    assign s_o  = sum[SLICE-1:0];
    assign co_o = sum[SLICE];
    // The MSB sum bit is x^y^cin, so the incoming carry falls out by XOR-ing the operands back off.
    assign cm_o = x_i[SLICE-1] ^ y_i[SLICE-1] ^ sum[SLICE-1];

endmodule

// File: rtl/seq_addsub.sv
// Sequential WIDTH-bit add/subtract that processes SLICE bits per clock through one shared slice adder.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_addsub_if.slave  bus,
    output state_t       state_o
);

    localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - SLICE);

    if (SLICE == 0 || (WIDTH % ((SLICE == 0) ? 1 : SLICE)) != 0) begin : g_bad_cfg
        $error("seq_addsub: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;

    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh, b_sh, res_new;
    logic [SLICE-1:0] x, y, s;
    logic             co, cm;

    // b_q already holds the effective operand (~B for subtract), so the datapath is add-only.
    assign base    = 32'(k_q) * 32'(SLICE);
    assign a_sh    = a_q >> base;
    assign b_sh    = b_q >> base;
    assign x       = a_sh[SLICE-1:0];
    assign y       = b_sh[SLICE-1:0];
    assign res_new = (res_q & ~(SLICE_MASK << base)) | (WIDTH'(s) << base);

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .x_i  (x),
        .y_i  (y),
        .ci_i (carry_q),
        .s_o  (s),
        .co_o (co),
        .cm_o (cm)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d   = res_new;
                carry_d = co;
                k_d     = k_q + IDX_W'(1);
                if (k_q == LAST_IDX) begin
                    k_d             = '0;
                    flags_d[FLAG_N] = res_new[WIDTH-1];
                    flags_d[FLAG_Z] = (res_new == '0);
                    flags_d[FLAG_C] = co;
                    flags_d[FLAG_V] = cm ^ co;
                    state_d         = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.flags     = flags_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed corner cases plus random operations against an arithmetic reference.
module tb_seq_addsub;
    import seq_addsub_pkg::*;

    localparam int NSL8 = 2;

    logic   clk;
    logic   rst;
    state_t st8, st16;
    int     checks = 0;
    int     errors = 0;
    logic [11:0] exp_q[$];

    seq_addsub_if #(.WIDTH(8))  bus8 ();
    seq_addsub_if #(.WIDTH(16)) bus16 ();

    seq_addsub #(.WIDTH(8), .SLICE(4)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus8.slave),
        .state_o (st8)
    );

    seq_addsub #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus16.slave),
        .state_o (st16)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: modular sum for result/C, true signed range test for V.
    function automatic void ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                      input bit s, input bit c,
                                      output longint unsigned res, output logic [3:0] fl);
        longint unsigned mask, bp, full;
        longint sa, sb, sr, lim;
        mask = (64'd1 << w) - 64'd1;
        bp   = s ? (~b & mask) : b;
        full = a + bp + (s ? 64'd1 : 64'(c));
        res  = full & mask;
        lim  = longint'(64'd1 << (w - 1));
        sa   = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (b >= 64'(lim)) ? longint'(b) - 2 * lim : longint'(b);
        sr   = s ? sa - sb : sa + sb + longint'(c);
        fl[FLAG_N] = ((res >> (w - 1)) & 64'd1) != 0;
        fl[FLAG_Z] = (res == 0);
        fl[FLAG_C] = ((full >> w) & 64'd1) != 0;
        fl[FLAG_V] = (sr >= lim) || (sr < -lim);
    endfunction

    // Driver for the 8-bit instance: one full transaction including DONE backpressure.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                           input int hold);
        int lat;
        logic [11:0] exp;
        lat = 0;
        while (!bus8.in_ready && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check("in_ready_before_accept", 32'(bus8.in_ready), 32'd1);
        bus8.a = a; bus8.b = b; bus8.sub = s; bus8.cin = c;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus8.sub = 1'($urandom); bus8.cin = 1'($urandom);
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'(NSL8));
        check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
        check("result", 32'(bus8.result), 32'(exp[7:0]));
        check("flags", 32'(bus8.flags), 32'(exp[11:8]));
        check("in_ready_in_done", 32'(bus8.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = 1'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", 32'(bus8.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus8.in_ready), 32'd0);
            check("hold_result", 32'(bus8.result), 32'(exp[7:0]));
            check("hold_flags", 32'(bus8.flags), 32'(exp[11:8]));
        end
        // in_valid stays high across the transfer edge: it must not be taken.
        bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        check("post_xfer_out_valid", 32'(bus8.out_valid), 32'd0);
        check("post_xfer_in_ready", 32'(bus8.in_ready), 32'd1);
        check("post_xfer_state", 32'(st8), 32'(IDLE));
        bus8.out_ready = 1'b0; bus8.in_valid = 1'b0;
    endtask

    task automatic push_model8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
        longint unsigned r;
        logic [3:0] f;
        ref_model(8, 64'(a), 64'(b), s, c, r, f);
        exp_q.push_back({f, r[7:0]});
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                            input logic [15:0] exp_r, input logic [3:0] exp_f);
        int lat;
        bus16.a = a; bus16.b = b; bus16.sub = s; bus16.cin = c; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
        lat = 0;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("w16_latency", 32'(lat), 32'd1);
        check("w16_result", 32'(bus16.result), 32'(exp_r));
        check("w16_flags", 32'(bus16.flags), 32'(exp_f));
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check("w16_in_ready", 32'(bus16.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic rs, rc;
        logic [15:0] wa, wb;
        longint unsigned wr;
        logic [3:0] wf;

        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0; bus8.cin = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0; bus16.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_result", 32'(bus8.result), 32'd0);
        check("rst_flags", 32'(bus8.flags), 32'd0);
        check("rst_state", 32'(st8), 32'(IDLE));
        check("rst_w16_in_ready", 32'(bus16.in_ready), 32'd1);

        // Directed corner cases with hand-derived {flags, result}
        exp_q.push_back({4'b0110, 8'h00}); run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        exp_q.push_back({4'b1001, 8'h80}); run_op8(8'h7F, 8'h01, 1'b0, 1'b0, 1);
        exp_q.push_back({4'b0000, 8'h31}); run_op8(8'h10, 8'h20, 1'b0, 1'b1, 0);
        exp_q.push_back({4'b1000, 8'hFE}); run_op8(8'h05, 8'h07, 1'b1, 1'b0, 0);
        exp_q.push_back({4'b0011, 8'h7F}); run_op8(8'h80, 8'h01, 1'b1, 1'b1, 5);

        // Reset one cycle after accept aborts the operation
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", 32'(st8), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            check("abort_out_valid", 32'(bus8.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("abort_in_ready", 32'(bus8.in_ready), 32'd1);
        check("abort_result", 32'(bus8.result), 32'd0);
        check("abort_flags", 32'(bus8.flags), 32'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            push_model8(ra, rb, rs, rc);
            run_op8(ra, rb, rs, rc, $urandom_range(0, 3));
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Single-slice configuration
        run_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0110);
        for (int n = 0; n < 6; n++) begin
            wa = 16'($urandom); wb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            ref_model(16, 64'(wa), 64'(wb), rs, rc, wr, wf);
            run_op16(wa, wb, rs, rc, wr[15:0], wf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
